// File: rtl/rtg4_ccc_reset_sequencer.sv
// rtl/rtg4_ccc_reset_sequencer.sv - CCC lock qualifier and two-stage fabric/core reset release
//
// Runs on the CCC GL0 clock. Synchronises the asynchronous PLL_LOCK and requires it
// to stay high for LOCK_STABLE_CYCLES before releasing FABRIC_RESET_N. It then
// releases CORE_RESET_N CORE_DELAY_CYCLES later. Loss of lock after fabric release
// pulls both resets low, pulses LOCK_LOST and bumps a saturating loss counter.
//
// Optional feature macro: RST_SEQ_SOFT_RESET_EN adds SOFT_RESET_REQ. A level request
// in RUN re-asserts CORE_RESET_N only, and re-releases it after the request drops.
//
// Ports:
//   CLK              in   fabric clock (CCC GL0)
//   RESETN           in   asynchronous active-low reset
//   PLL_LOCK         in   CCC LOCK, asynchronous to CLK
//   SOFT_RESET_REQ   in   core-only reset request (RST_SEQ_SOFT_RESET_EN builds only)
//   FABRIC_RESET_N   out  active-low reset for interconnect and peripherals
//   CORE_RESET_N     out  active-low reset for the processor core
//   LOCK_LOST        out  one-cycle pulse per lock loss after fabric release
//   LOCK_LOSS_COUNT  out  saturating lock-loss count

module rtg4_ccc_reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int CORE_DELAY_CYCLES  = 16,
    parameter int LOSS_CNT_WIDTH     = 8
) (
    input  logic                      CLK,
    input  logic                      RESETN,
    input  logic                      PLL_LOCK,
`ifdef RST_SEQ_SOFT_RESET_EN
    input  logic                      SOFT_RESET_REQ,
`endif
    output logic                      FABRIC_RESET_N,
    output logic                      CORE_RESET_N,
    output logic                      LOCK_LOST,
    output logic [LOSS_CNT_WIDTH-1:0] LOCK_LOSS_COUNT
);

    localparam int MAX_CYCLES = (LOCK_STABLE_CYCLES > CORE_DELAY_CYCLES) ?
                                LOCK_STABLE_CYCLES : CORE_DELAY_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] STABLE_TGT = CNT_W'(LOCK_STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CORE_TGT   = CNT_W'(CORE_DELAY_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK  = 2'd0,
        STABLE     = 2'd1,
        FABRIC_REL = 2'd2,
        RUN        = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0]    sync_q;
    logic                      lock_s;
    logic                      lost_d;
    logic                      soft_req;
    logic                      soft_pend_q, soft_pend_d;
    logic                      fabric_d, core_d;
    logic [LOSS_CNT_WIDTH-1:0] loss_cnt_d;

`ifdef RST_SEQ_SOFT_RESET_EN
    assign soft_req = SOFT_RESET_REQ;
`else
    assign soft_req = 1'b0;
`endif

    assign lock_s = sync_q[SYNC_STAGES-1];

    // State register; outputs are registered so the reset tree never sees decode glitches.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sync_q          <= '0;
            state_q         <= WAIT_LOCK;
            cnt_q           <= '0;
            soft_pend_q     <= 1'b0;
            FABRIC_RESET_N  <= 1'b0;
            CORE_RESET_N    <= 1'b0;
            LOCK_LOST       <= 1'b0;
            LOCK_LOSS_COUNT <= '0;
        end else begin
            sync_q          <= {sync_q[SYNC_STAGES-2:0], PLL_LOCK};
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            soft_pend_q     <= soft_pend_d;
            FABRIC_RESET_N  <= fabric_d;
            CORE_RESET_N    <= core_d;
            LOCK_LOST       <= lost_d;
            LOCK_LOSS_COUNT <= loss_cnt_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lost_d      = 1'b0;
        soft_pend_d = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                    // The entry cycle already counts as one stable cycle.
                    cnt_d   = CNT_W'(1);
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_TGT) begin
                    state_d = FABRIC_REL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FABRIC_REL: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    lost_d  = 1'b1;
                end else if (soft_req || soft_pend_q) begin
                    // Hold the delay at zero while the request is high and for the
                    // edge that first samples it low, so the core delay restarts from
                    // that edge exactly like a fresh fabric release.
                    cnt_d       = '0;
                    soft_pend_d = soft_req;
                end else if (cnt_q == CORE_TGT) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    lost_d  = 1'b1;
                end else if (soft_req) begin
                    state_d     = FABRIC_REL;
                    cnt_d       = '0;
                    soft_pend_d = 1'b1;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the next state, so resets move on the transition edge.
    always_comb begin
        fabric_d   = (state_d == FABRIC_REL) || (state_d == RUN);
        core_d     = (state_d == RUN);
        loss_cnt_d = LOCK_LOSS_COUNT;
        if (lost_d && !(&LOCK_LOSS_COUNT)) begin
            loss_cnt_d = LOCK_LOSS_COUNT + LOSS_CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_rtg4_ccc_reset_sequencer.sv
// tb/tb_rtg4_ccc_reset_sequencer.sv - directed self-checking bench for rtg4_ccc_reset_sequencer

module tb_rtg4_ccc_reset_sequencer;

    logic       clk = 1'b0;
    logic       resetn, pll_lock, soft_req;
    logic       fabric, core, lost;
    logic [7:0] loss_cnt;

    logic       rst2, lock2, soft2;
    logic       fabric2, core2, lost2;
    logic [1:0] loss_cnt2;

    int vectors     = 0;
    int miscompares = 0;
    int edge_no     = 0;
    int inv_viol    = 0;
    int lost_cycles = 0;
    int inv_viol2   = 0;
    int lost_cycles2 = 0;
    int sat_exp [5] = '{1, 2, 3, 3, 3};

    always #5 clk = ~clk;

    rtg4_ccc_reset_sequencer dut (
        .CLK             (clk),
        .RESETN          (resetn),
        .PLL_LOCK        (pll_lock),
`ifdef RST_SEQ_SOFT_RESET_EN
        .SOFT_RESET_REQ  (soft_req),
`endif
        .FABRIC_RESET_N  (fabric),
        .CORE_RESET_N    (core),
        .LOCK_LOST       (lost),
        .LOCK_LOSS_COUNT (loss_cnt)
    );

    rtg4_ccc_reset_sequencer #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (4),
        .CORE_DELAY_CYCLES  (2),
        .LOSS_CNT_WIDTH     (2)
    ) dut_small (
        .CLK             (clk),
        .RESETN          (rst2),
        .PLL_LOCK        (lock2),
`ifdef RST_SEQ_SOFT_RESET_EN
        .SOFT_RESET_REQ  (soft2),
`endif
        .FABRIC_RESET_N  (fabric2),
        .CORE_RESET_N    (core2),
        .LOCK_LOST       (lost2),
        .LOCK_LOSS_COUNT (loss_cnt2)
    );

    always @(negedge clk) begin
        if (core && !fabric) inv_viol++;
        if (lost) lost_cycles++;
        if (core2 && !fabric2) inv_viol2++;
        if (lost2) lost_cycles2++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_no);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            edge_no++;
        end
        #1;
    endtask

    task automatic go_to(input int target);
        step(target - edge_no);
    endtask

    initial begin
        resetn = 1'b0; pll_lock = 1'b0; soft_req = 1'b0;
        rst2 = 1'b0; lock2 = 1'b0; soft2 = 1'b0;

        // Power-up
        step(5);
        check_eq("rst_fabric", fabric, 0);
        check_eq("rst_core", core, 0);
        check_eq("rst_lost", lost, 0);
        check_eq("rst_count", loss_cnt, 0);
        resetn = 1'b1;
        edge_no = 0;
        go_to(9);
        pll_lock = 1'b1;
        go_to(1035);
        check_eq("pu_fabric_early", fabric, 0);
        go_to(1036);
        check_eq("pu_fabric_rise", fabric, 1);
        check_eq("pu_core_held", core, 0);
        go_to(1051);
        check_eq("pu_core_early", core, 0);
        go_to(1052);
        check_eq("pu_core_rise", core, 1);
        check_eq("pu_count", loss_cnt, 0);

        // Loss in RUN, 10-cycle drop
        go_to(1060);
        pll_lock = 1'b0;
        go_to(1062);
        check_eq("loss_fabric_still", fabric, 1);
        check_eq("loss_lost_early", lost, 0);
        go_to(1063);
        check_eq("loss_fabric", fabric, 0);
        check_eq("loss_core", core, 0);
        check_eq("loss_pulse", lost, 1);
        check_eq("loss_count1", loss_cnt, 1);
        go_to(1064);
        check_eq("loss_pulse_end", lost, 0);
        go_to(1070);
        pll_lock = 1'b1;
        go_to(2096);
        check_eq("relock_fabric_early", fabric, 0);
        go_to(2097);
        check_eq("relock_fabric", fabric, 1);
        check_eq("relock_count", loss_cnt, 1);
        go_to(2112);
        check_eq("relock_core_early", core, 0);
        go_to(2113);
        check_eq("relock_core", core, 1);

        // Second loss, then RESETN asserted in FABRIC_REL
        go_to(2120);
        pll_lock = 1'b0;
        go_to(2123);
        check_eq("loss2_count", loss_cnt, 2);
        go_to(2125);
        pll_lock = 1'b1;
        go_to(3152);
        check_eq("fr_fabric", fabric, 1);
        go_to(3155);
        check_eq("fr_core", core, 0);
        resetn = 1'b0;
        #1;
        check_eq("async_fabric", fabric, 0);
        check_eq("async_core", core, 0);
        check_eq("async_lost", lost, 0);
        check_eq("async_count", loss_cnt, 0);
        pll_lock = 1'b0;
        step(2);

        // Glitch during STABLE restarts qualification
        resetn = 1'b1;
        edge_no = 0;
        pll_lock = 1'b1;
        go_to(500);
        pll_lock = 1'b0;
        go_to(503);
        pll_lock = 1'b1;
        go_to(1027);
        check_eq("glitch_no_release", fabric, 0);
        go_to(1529);
        check_eq("glitch_fabric_early", fabric, 0);
        go_to(1530);
        check_eq("glitch_fabric", fabric, 1);
        go_to(1546);
        check_eq("glitch_core", core, 1);
        check_eq("glitch_count", loss_cnt, 0);

`ifdef RST_SEQ_SOFT_RESET_EN
        // Core-only soft reset, request high 4 cycles
        go_to(1550);
        soft_req = 1'b1;
        go_to(1551);
        check_eq("soft_core_low", core, 0);
        check_eq("soft_fabric_hold", fabric, 1);
        go_to(1554);
        soft_req = 1'b0;
        go_to(1560);
        check_eq("soft_fabric_mid", fabric, 1);
        go_to(1570);
        check_eq("soft_core_early", core, 0);
        go_to(1571);
        check_eq("soft_core_rise", core, 1);
        check_eq("soft_fabric_end", fabric, 1);
        check_eq("soft_count", loss_cnt, 0);
`endif

        // Small instance: exact short latency, then counter saturation
        rst2 = 1'b1;
        edge_no = 0;
        lock2 = 1'b1;
        go_to(6);
        check_eq("small_fabric_early", fabric2, 0);
        go_to(7);
        check_eq("small_fabric", fabric2, 1);
        check_eq("small_core_held", core2, 0);
        go_to(8);
        check_eq("small_core_early", core2, 0);
        go_to(9);
        check_eq("small_core", core2, 1);
        for (int i = 0; i < 5; i++) begin
            int k;
            k = 0;
            while (!core2 && k < 50) begin
                step(1);
                k++;
            end
            check_eq("sat_run", core2, 1);
            lock2 = 1'b0;
            step(3);
            check_eq("sat_count", loss_cnt2, sat_exp[i]);
            step(3);
            lock2 = 1'b1;
        end

        step(2);
        check_eq("invariant", inv_viol, 0);
        check_eq("lost_cycles", lost_cycles, 2);
        check_eq("invariant_small", inv_viol2, 0);
        check_eq("lost_cycles_small", lost_cycles2, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
